// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: funct3 codes, data_mem sign_mask values,
// the response-pipeline entry and the default data_mem read latency.
package lsu_pkg;

  localparam int MEM_RD_LATENCY_DEF = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // sign_mask = {sign-extend, size lanes}
  localparam logic [3:0] SM_LB  = 4'b1001;
  localparam logic [3:0] SM_LH  = 4'b1011;
  localparam logic [3:0] SM_LW  = 4'b0111;
  localparam logic [3:0] SM_LBU = 4'b0001;
  localparam logic [3:0] SM_LHU = 4'b0011;
  localparam logic [3:0] SM_SB  = 4'b0001;
  localparam logic [3:0] SM_SH  = 4'b0011;
  localparam logic [3:0] SM_SW  = 4'b0111;

  typedef struct packed {
    logic       valid;
    logic       is_load;
    logic       fault;
    logic [4:0] rd;
  } rsp_entry_t;

  localparam int RSP_ENTRY_W = $bits(rsp_entry_t);

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      3'b011:  return addr_lo[0];
      3'b111:  return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_decode.sv
// Combinational funct3/address decode into data_mem size lanes, sign flag and fault.
// align_en folds misalignment into the fault; illegal funct3 always faults.
module lsu_decode
  import lsu_pkg::*;
(
  input  logic       is_store,
  input  logic [2:0] funct3,
  input  logic [1:0] addr_lo,
  input  logic       align_en,
  output logic [2:0] size_mask,
  output logic       is_signed,
  output logic       fault
);

  logic [3:0] sm;
  logic       illegal;

  always_comb begin
    sm      = 4'b0000;
    illegal = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B:    sm = SM_SB;
        F3_H:    sm = SM_SH;
        F3_W:    sm = SM_SW;
        default: illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    sm = SM_LB;
        F3_H:    sm = SM_LH;
        F3_W:    sm = SM_LW;
        F3_BU:   sm = SM_LBU;
        F3_HU:   sm = SM_LHU;
        default: illegal = 1'b1;
      endcase
    end
  end

  assign size_mask = sm[2:0];
  assign is_signed = sm[3];
  assign fault     = illegal | (align_en & is_misaligned(sm[2:0], addr_lo));

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between memory stage and data_mem: registered issue, store bubble, fixed-latency
// in-order responses. Alignment faults are enabled by defining LSU_ALIGN_CHECK_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_RD_LATENCY = lsu_pkg::MEM_RD_LATENCY_DEF,
  parameter int RSP_DEPTH      = 1 + MEM_RD_LATENCY
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memread,
  output logic        mem_memwrite,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  output logic        rsp_valid,
  output logic [4:0]  rsp_rd,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic        busy
);

`ifdef LSU_ALIGN_CHECK_EN
  localparam logic ALIGN_EN = 1'b1;
`else
  localparam logic ALIGN_EN = 1'b0;
`endif

  logic       ready_en;
  logic       bubble;
  logic       accept;
  logic       rsp_load_ok;
  logic [2:0] dec_size;
  logic       dec_signed;
  logic       dec_fault;
  rsp_entry_t pipe [RSP_DEPTH];

  lsu_decode u_decode (
    .is_store  (req_is_store),
    .funct3    (req_funct3),
    .addr_lo   (req_addr[1:0]),
    .align_en  (ALIGN_EN),
    .size_mask (dec_size),
    .is_signed (dec_signed),
    .fault     (dec_fault)
  );

  assign req_ready = ready_en & ~bubble & ~reset;
  assign accept    = req_valid & req_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_en       <= 1'b0;
      bubble         <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memread    <= 1'b0;
      mem_memwrite   <= 1'b0;
      mem_sign_mask  <= '0;
      rsp_valid      <= 1'b0;
      rsp_rd         <= '0;
      rsp_fault      <= 1'b0;
      rsp_load_ok    <= 1'b0;
      for (int i = 0; i < RSP_DEPTH; i++) pipe[i] <= '0;
    end else begin
      ready_en     <= 1'b1;
      // A store holds off the next accept one cycle so a trailing load sees its write.
      bubble       <= accept & req_is_store;
      mem_memread  <= accept & ~req_is_store & ~dec_fault;
      mem_memwrite <= accept & req_is_store & ~dec_fault;
      if (accept) begin
        mem_addr       <= req_addr;
        mem_write_data <= req_wdata;
        mem_sign_mask  <= {dec_signed, dec_size};
        pipe[0]        <= '{valid: 1'b1, is_load: ~req_is_store, fault: dec_fault, rd: req_rd};
      end else begin
        pipe[0] <= '0;
      end
      for (int i = 1; i < RSP_DEPTH; i++) pipe[i] <= pipe[i-1];
      rsp_valid   <= pipe[RSP_DEPTH-1].valid & (pipe[RSP_DEPTH-1].is_load | pipe[RSP_DEPTH-1].fault);
      rsp_rd      <= pipe[RSP_DEPTH-1].valid ? pipe[RSP_DEPTH-1].rd : 5'd0;
      rsp_fault   <= pipe[RSP_DEPTH-1].valid & pipe[RSP_DEPTH-1].fault;
      rsp_load_ok <= pipe[RSP_DEPTH-1].valid & pipe[RSP_DEPTH-1].is_load & ~pipe[RSP_DEPTH-1].fault;
    end
  end

  // read_data lands on the same edge the response strobe is registered
  assign rsp_data = rsp_load_ok ? mem_read_data : 32'h0;

  always_comb begin
    busy = bubble;
    for (int i = 0; i < RSP_DEPTH; i++) busy = busy | pipe[i].valid;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural data_mem (2-cycle read latency).
module tb_load_store_unit;

`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALN = 1'b1;
`else
  localparam bit ALN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memread;
  logic        mem_memwrite;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data = 32'h0;
  logic        rsp_valid;
  logic [4:0]  rsp_rd;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_memread(mem_memread),
    .mem_memwrite(mem_memwrite), .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .rsp_fault(rsp_fault),
    .busy(busy)
  );

  // behavioural data_mem: samples on the edge ending the pulse, read_data two edges later
  logic [31:0] mem_words [0:255];
  logic [31:0] rq0 = 32'h0, rq1 = 32'h0;

  function automatic logic [31:0] fmt(input logic [31:0] w, input logic [1:0] a, input logic [3:0] m);
    logic [7:0]  b;
    logic [15:0] h;
    case (a)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (m[2:0])
      3'b001:  return m[3] ? {{24{b[7]}}, b} : {24'h0, b};
      3'b011:  return m[3] ? {{16{h[15]}}, h} : {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] d, input logic [1:0] a,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = w;
    case (m[2:0])
      3'b001: case (a)
        2'd0: r[7:0]   = d[7:0];
        2'd1: r[15:8]  = d[7:0];
        2'd2: r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
      3'b011: if (a[1]) r[31:16] = d[15:0]; else r[15:0] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_memwrite)
      mem_words[mem_addr[9:2]] <= merge(mem_words[mem_addr[9:2]], mem_write_data, mem_addr[1:0], mem_sign_mask);
    rq0 <= mem_memread ? fmt(mem_words[mem_addr[9:2]], mem_addr[1:0], mem_sign_mask) : 32'h0;
    rq1 <= rq0;
    mem_read_data <= rq1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic [3:0]  mask;
    logic [1:0]  pulse;   // 0 none, 1 read, 2 write
    logic        rsp;
    logic        fault;
    logic [31:0] data;
  } vec_t;

  vec_t vt [13];

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [4:0] rd);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3;
    req_addr = a; req_wdata = wd; req_rd = rd;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int guard;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(posedge clk); #1; guard++;
    end
    if (!req_ready) begin
      check($sformatf("v%0d_ready_timeout", idx), 32'(req_ready), 32'd1);
      return;
    end
    drive(v.st, v.f3, v.addr, v.wdata, v.rd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check($sformatf("v%0d_memread", idx), 32'(mem_memread), 32'(v.pulse == 2'd1));
    check($sformatf("v%0d_memwrite", idx), 32'(mem_memwrite), 32'(v.pulse == 2'd2));
    check($sformatf("v%0d_busy", idx), 32'(busy), 32'd1);
    if (v.pulse != 2'd0) begin
      check($sformatf("v%0d_sign_mask", idx), 32'(mem_sign_mask), 32'(v.mask));
      check($sformatf("v%0d_mem_addr", idx), mem_addr, v.addr);
    end
    if (v.pulse == 2'd2) check($sformatf("v%0d_wdata", idx), mem_write_data, v.wdata);
    @(posedge clk); #1;
    check($sformatf("v%0d_pulse_end", idx), 32'(mem_memread | mem_memwrite), 32'd0);
    @(posedge clk); #1;
    check($sformatf("v%0d_rsp_early", idx), 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'(v.rsp));
    if (v.rsp) begin
      check($sformatf("v%0d_rsp_rd", idx), 32'(rsp_rd), 32'(v.rd));
      check($sformatf("v%0d_rsp_fault", idx), 32'(rsp_fault), 32'(v.fault));
      check($sformatf("v%0d_rsp_data", idx), rsp_data, v.data);
    end
    @(posedge clk); #1;
    check($sformatf("v%0d_rsp_strobe_end", idx), 32'(rsp_valid), 32'd0);
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_data [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem_words[i] = 32'h0;
    mem_words[8'h02] = 32'h0000_80FF;   // 0x1008

    //           st    f3      addr         wdata         rd     mask     pulse  rsp   fault data
    vt[0]  = '{1'b1, 3'b010, 32'h1004, 32'hDEADBEEF, 5'd0,  4'b0111, 2'd2, 1'b0, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 3'b010, 32'h1004, 32'h0,        5'd5,  4'b0111, 2'd1, 1'b1, 1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b0, 3'b000, 32'h1008, 32'h0,        5'd1,  4'b1001, 2'd1, 1'b1, 1'b0, 32'hFFFFFFFF};
    vt[3]  = '{1'b0, 3'b100, 32'h1009, 32'h0,        5'd2,  4'b0001, 2'd1, 1'b1, 1'b0, 32'h00000080};
    vt[4]  = '{1'b0, 3'b001, 32'h1008, 32'h0,        5'd3,  4'b1011, 2'd1, 1'b1, 1'b0, 32'hFFFF80FF};
    vt[5]  = '{1'b0, 3'b101, 32'h100A, 32'h0,        5'd4,  4'b0011, 2'd1, 1'b1, 1'b0, 32'h0};
    vt[6]  = '{1'b1, 3'b000, 32'h100C, 32'h000000AB, 5'd0,  4'b0001, 2'd2, 1'b0, 1'b0, 32'h0};
    vt[7]  = '{1'b0, 3'b100, 32'h100C, 32'h0,        5'd6,  4'b0001, 2'd1, 1'b1, 1'b0, 32'h000000AB};
    vt[8]  = '{1'b0, 3'b011, 32'h1004, 32'h0,        5'd8,  4'b0000, 2'd0, 1'b1, 1'b1, 32'h0};
    vt[9]  = '{1'b1, 3'b100, 32'h1004, 32'h12345678, 5'd9,  4'b0000, 2'd0, 1'b1, 1'b1, 32'h0};
    vt[10] = '{1'b0, 3'b001, 32'h1003, 32'h0,        5'd7,  4'b1011, ALN ? 2'd0 : 2'd1, 1'b1, ALN, 32'h0};
    vt[11] = '{1'b1, 3'b001, 32'h1010, 32'h00001234, 5'd0,  4'b0011, 2'd2, 1'b0, 1'b0, 32'h0};
    vt[12] = '{1'b0, 3'b001, 32'h1010, 32'h0,        5'd10, 4'b1011, 2'd1, 1'b1, 1'b0, 32'h00001234};

    // reset held with a pending request
    reset = 1'b1;
    drive(1'b0, 3'b010, 32'h1004, 32'h0, 5'd1);
    repeat (3) begin
      @(posedge clk); #1;
      check("rst_memread", 32'(mem_memread | mem_memwrite), 32'd0);
      check("rst_ready", 32'(req_ready), 32'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_busy", 32'(busy), 32'd0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_sign_mask", 32'(mem_sign_mask), 32'd0);
    check("post_rst_rsp_data", rsp_data, 32'd0);

    for (int i = 0; i < 13; i++) run_vec(vt[i], i);

    // store bubble then dependent load
    drive(1'b1, 3'b010, 32'h1014, 32'hCAFEF00D, 5'd0);
    @(posedge clk); #1;
    check("bubble_ready", 32'(req_ready), 32'd0);
    check("bubble_memwrite", 32'(mem_memwrite), 32'd1);
    drive(1'b0, 3'b010, 32'h1014, 32'h0, 5'd12);
    @(posedge clk); #1;
    check("bubble_ready_back", 32'(req_ready), 32'd1);
    check("bubble_no_pulse", 32'(mem_memread | mem_memwrite), 32'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("raw_memread", 32'(mem_memread), 32'd1);
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    check("raw_rsp_valid", 32'(rsp_valid), 32'd1);
    check("raw_rsp_rd", 32'(rsp_rd), 32'd12);
    check("raw_rsp_data", rsp_data, 32'hCAFEF00D);
    repeat (2) @(posedge clk);
    #1;

    // four back-to-back loads
    b2b_addr[0] = 32'h1004; b2b_data[0] = 32'hDEADBEEF;
    b2b_addr[1] = 32'h1008; b2b_data[1] = 32'h000080FF;
    b2b_addr[2] = 32'h100C; b2b_data[2] = 32'h000000AB;
    b2b_addr[3] = 32'h1010; b2b_data[3] = 32'h00001234;
    for (int c = 0; c < 8; c++) begin
      if (c < 4) begin
        check($sformatf("b2b_ready%0d", c), 32'(req_ready), 32'd1);
        drive(1'b0, 3'b010, b2b_addr[c], 32'h0, 5'(c + 1));
      end else begin
        req_valid = 1'b0;
      end
      @(posedge clk); #1;
      check($sformatf("b2b_rsp_valid_c%0d", c), 32'(rsp_valid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) begin
        check($sformatf("b2b_rsp_rd_c%0d", c), 32'(rsp_rd), 32'(c - 2));
        check($sformatf("b2b_rsp_data_c%0d", c), rsp_data, b2b_data[c-3]);
      end
    end

    // reset the cycle after a load accept discards it
    drive(1'b0, 3'b010, 32'h1004, 32'h0, 5'd13);
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("mid_rst_no_rsp%0d", c), 32'(rsp_valid), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
